// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the microwave cook-time controller.
package cook_timer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] mt;
    logic [DIGIT_W-1:0] mo;
    logic [DIGIT_W-1:0] st;
    logic [DIGIT_W-1:0] so;
  } bcd_time_t;

endpackage

// File: rtl/bcd_digit_clamp.sv
// Saturates a raw 4-bit keypad code into the BCD range 0-9.
module bcd_digit_clamp
  import cook_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] raw_digit,
  output logic [DIGIT_W-1:0] bcd_digit
);

  always_comb begin
    bcd_digit = raw_digit;
    if (raw_digit > BCD_MAX) bcd_digit = BCD_MAX;
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: MM:SS keypad entry, 1 Hz BCD countdown, magnetron and beep.
// Optional macro COOK_TIMER_QUICK_START_EN: zero-time start loads QUICK_SEC, start in COOK adds 30 s.
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int unsigned BEEP_TICKS = 3,
  parameter int unsigned QUICK_SEC  = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [DIGIT_W-1:0]  key_digit,
  input  logic                start,
  input  logic                stop,
  input  logic                door_open,
  input  logic                tick_1hz,
  output logic [DIGIT_W-1:0]  min_tens,
  output logic [DIGIT_W-1:0]  min_ones,
  output logic [DIGIT_W-1:0]  sec_tens,
  output logic [DIGIT_W-1:0]  sec_ones,
  output logic                magnetron_on,
  output logic                done_beep,
  output logic [STATE_W-1:0]  state_o
);

  localparam bcd_time_t QUICK_TIME = {DIGIT_W'(QUICK_SEC / 600),
                                      DIGIT_W'((QUICK_SEC / 60) % 10),
                                      DIGIT_W'((QUICK_SEC % 60) / 10),
                                      DIGIT_W'(QUICK_SEC % 10)};

  state_t             state_q;
  bcd_time_t          time_q;
  logic [DIGIT_W-1:0] beep_cnt;
  logic               door_q;
  logic [DIGIT_W-1:0] key_bcd;
  bcd_time_t          time_dec;
  logic               time_zero;
  logic               start_ok;
  logic               door_rise;

  bcd_digit_clamp u_clamp (
    .raw_digit (key_digit),
    .bcd_digit (key_bcd)
  );

  // Borrow chain: seconds-ones -> seconds-tens (wraps to 5) -> minutes-ones -> minutes-tens.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.so != '0) begin
      r.so = t.so - 4'd1;
    end else begin
      r.so = BCD_MAX;
      if (t.st != '0) begin
        r.st = t.st - 4'd1;
      end else begin
        r.st = SEC_TENS_MAX;
        if (t.mo != '0) begin
          r.mo = t.mo - 4'd1;
        end else begin
          r.mo = BCD_MAX;
          r.mt = (t.mt != '0) ? t.mt - 4'd1 : BCD_MAX;
        end
      end
    end
    return r;
  endfunction

`ifdef COOK_TIMER_QUICK_START_EN
  // Adds 30 s; seconds-tens carries past 5 into the minutes, whole value saturates at 99:59.
  function automatic bcd_time_t bcd_add30(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.st + 4'd3 > SEC_TENS_MAX) begin
      r.st = t.st + 4'd3 - 4'd6;
      if (r.st > SEC_TENS_MAX) r.st = SEC_TENS_MAX;
      if (t.mt == BCD_MAX && t.mo == BCD_MAX) begin
        r = {BCD_MAX, BCD_MAX, SEC_TENS_MAX, BCD_MAX};
      end else if (t.mo == BCD_MAX) begin
        r.mo = '0;
        r.mt = t.mt + 4'd1;
      end else begin
        r.mo = t.mo + 4'd1;
      end
    end else begin
      r.st = t.st + 4'd3;
    end
    return r;
  endfunction
`endif

  always_comb begin
    time_dec  = bcd_dec(time_q);
    time_zero = (time_q == '0);
    door_rise = door_open && !door_q;
`ifdef COOK_TIMER_QUICK_START_EN
    start_ok  = start && !door_open;
`else
    start_ok  = start && !door_open && !time_zero;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      time_q       <= '0;
      magnetron_on <= 1'b0;
      done_beep    <= 1'b0;
      beep_cnt     <= '0;
      door_q       <= 1'b0;
    end else begin
      door_q <= door_open;
      case (state_q)
        IDLE, ENTRY: begin
          if (stop) begin
            time_q  <= '0;
            state_q <= IDLE;
          end else if (start_ok) begin
            state_q      <= COOK;
            magnetron_on <= 1'b1;
            // Only reachable in the quick-start build; start_ok excludes zero time otherwise.
            if (time_zero) time_q <= QUICK_TIME;
          end else if (key_valid) begin
            time_q  <= {time_q.mo, time_q.st, time_q.so, key_bcd};
            state_q <= ENTRY;
          end
        end
        COOK: begin
          if (stop || door_open) begin
            state_q      <= PAUSE;
            magnetron_on <= 1'b0;
`ifdef COOK_TIMER_QUICK_START_EN
          end else if (start) begin
            time_q <= bcd_add30(time_q);
`endif
          end else if (tick_1hz) begin
            time_q <= time_dec;
            if (time_dec == '0) begin
              state_q      <= DONE;
              magnetron_on <= 1'b0;
              done_beep    <= 1'b1;
              beep_cnt     <= DIGIT_W'(BEEP_TICKS);
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            time_q  <= '0;
            state_q <= IDLE;
          end else if (start && !door_open) begin
            state_q      <= COOK;
            magnetron_on <= 1'b1;
          end
        end
        DONE: begin
          if (stop || key_valid || start || door_rise) begin
            state_q   <= IDLE;
            done_beep <= 1'b0;
            beep_cnt  <= '0;
          end else if (tick_1hz) begin
            if (beep_cnt <= 4'd1) begin
              state_q   <= IDLE;
              done_beep <= 1'b0;
              beep_cnt  <= '0;
            end else begin
              beep_cnt <= beep_cnt - 4'd1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          time_q       <= '0;
          magnetron_on <= 1'b0;
          done_beep    <= 1'b0;
          beep_cnt     <= '0;
        end
      endcase
    end
  end

  assign min_tens = time_q.mt;
  assign min_ones = time_q.mo;
  assign sec_tens = time_q.st;
  assign sec_ones = time_q.so;
  assign state_o  = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed self-checking bench for cook_timer_ctrl (quick-start checks follow COOK_TIMER_QUICK_START_EN).
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_open = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       magnetron_on, done_beep;
  logic [2:0] state_o;
  logic [15:0] disp;

  int tests = 0;
  int fails = 0;

  cook_timer_ctrl #(.BEEP_TICKS(3), .QUICK_SEC(30)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_open(door_open), .tick_1hz(tick_1hz),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .magnetron_on(magnetron_on), .done_beep(done_beep), .state_o(state_o)
  );

  always #5 clk = ~clk;
  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  // One clock with the given one-cycle pulses, then outputs are sampled 1 ns after the edge.
  task automatic step(input logic kv, input logic [3:0] kd, input logic st, input logic sp,
                      input logic tk);
    key_valid = kv; key_digit = kd; start = st; stop = sp; tick_1hz = tk;
    @(posedge clk); #1;
    key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tests++; if (disp !== 16'h0000) begin fails++; $display("FAIL reset_disp: got %h expected %h", disp, 16'h0000); end
    tests++; if (state_o !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    tests++; if (magnetron_on !== 1'b0) begin fails++; $display("FAIL reset_mag: got %b expected 0", magnetron_on); end
    tests++; if (done_beep !== 1'b0) begin fails++; $display("FAIL reset_beep: got %b expected 0", done_beep); end
  endtask

  task automatic test_countdown;
    press(4'd1); press(4'd3); press(4'd0);
    tests++; if (disp !== 16'h0130) begin fails++; $display("FAIL entry_disp: got %h expected 0130", disp); end
    tests++; if (state_o !== 3'd1) begin fails++; $display("FAIL entry_state: got %0d expected 1", state_o); end
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tests++; if (state_o !== 3'd2 || magnetron_on !== 1'b1) begin fails++; $display("FAIL start_cook: got state %0d mag %b expected 2 1", state_o, magnetron_on); end
    ticks(3);
    tests++; if (disp !== 16'h0127) begin fails++; $display("FAIL tick3: got %h expected 0127", disp); end
    ticks(27);
    tests++; if (disp !== 16'h0100) begin fails++; $display("FAIL tick30: got %h expected 0100", disp); end
    ticks(1);
    tests++; if (disp !== 16'h0059) begin fails++; $display("FAIL minute_borrow: got %h expected 0059", disp); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tests++; if (disp !== 16'h0000 || state_o !== 3'd0) begin fails++; $display("FAIL stop_clear: got %h state %0d expected 0000 0", disp, state_o); end
  endtask

  task automatic test_clamp;
    press(4'd15); press(4'd7);
    tests++; if (disp !== 16'h0097) begin fails++; $display("FAIL clamp: got %h expected 0097", disp); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    tests++; if (disp !== 16'h2345) begin fails++; $display("FAIL shift: got %h expected 2345", disp); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    press(4'd9); press(4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    tests++; if (disp !== 16'h0089) begin fails++; $display("FAIL unnormalised: got %h expected 0089", disp); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_pause;
    press(4'd0); press(4'd5);
    door_open = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tests++; if (state_o !== 3'd1) begin fails++; $display("FAIL start_door_open: got state %0d expected 1", state_o); end
    door_open = 1'b0;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    door_open = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tests++; if (state_o !== 3'd3 || magnetron_on !== 1'b0) begin fails++; $display("FAIL door_pause: got state %0d mag %b expected 3 0", state_o, magnetron_on); end
    ticks(1);
    tests++; if (disp !== 16'h0005 || state_o !== 3'd3) begin fails++; $display("FAIL pause_hold: got %h state %0d expected 0005 3", disp, state_o); end
    door_open = 1'b0;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tests++; if (state_o !== 3'd2 || magnetron_on !== 1'b1) begin fails++; $display("FAIL resume: got state %0d mag %b expected 2 1", state_o, magnetron_on); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    tests++; if (disp !== 16'h0005 || state_o !== 3'd3) begin fails++; $display("FAIL stop_tick: got %h state %0d expected 0005 3", disp, state_o); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tests++; if (disp !== 16'h0000 || state_o !== 3'd0) begin fails++; $display("FAIL pause_stop: got %h state %0d expected 0000 0", disp, state_o); end
  endtask

  task automatic test_done;
    press(4'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    tests++; if (disp !== 16'h0000 || state_o !== 3'd4 || done_beep !== 1'b1 || magnetron_on !== 1'b0) begin fails++; $display("FAIL enter_done: got %h state %0d beep %b mag %b expected 0000 4 1 0", disp, state_o, done_beep, magnetron_on); end
    ticks(2);
    tests++; if (state_o !== 3'd4 || done_beep !== 1'b1) begin fails++; $display("FAIL beep_hold: got state %0d beep %b expected 4 1", state_o, done_beep); end
    ticks(1);
    tests++; if (state_o !== 3'd0 || done_beep !== 1'b0) begin fails++; $display("FAIL beep_end: got state %0d beep %b expected 0 0", state_o, done_beep); end
    press(4'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    press(4'd5);
    tests++; if (state_o !== 3'd0 || done_beep !== 1'b0 || disp !== 16'h0000) begin fails++; $display("FAIL key_in_done: got state %0d beep %b disp %h expected 0 0 0000", state_o, done_beep, disp); end
  endtask

  task automatic test_back_to_back;
    press(4'd2);
    step(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    tests++; if (state_o !== 3'd2 || disp !== 16'h0002) begin fails++; $display("FAIL start_key: got state %0d disp %h expected 2 0002", state_o, disp); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
`ifdef COOK_TIMER_QUICK_START_EN
    tests++; if (state_o !== 3'd2 || disp !== 16'h0030) begin fails++; $display("FAIL quick_start: got state %0d disp %h expected 2 0030", state_o, disp); end
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tests++; if (disp !== 16'h0100) begin fails++; $display("FAIL quick_add: got %h expected 0100", disp); end
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
`else
    tests++; if (state_o !== 3'd0 || magnetron_on !== 1'b0) begin fails++; $display("FAIL zero_start: got state %0d mag %b expected 0 0", state_o, magnetron_on); end
`endif
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_clamp();
    test_pause();
    test_done();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
- Microwave cook-time controller.
- Accepts keypad digits, clamps each to BCD 0-9 and shifts it into an MM:SS entry register.
- Counts the time down on a 1 Hz tick while cooking, and drives the magnetron enable and the completion beep.
- Sits between the keypad decoder and the 7-segment display / magnetron output logic.

Parameters:
BEEP_TICKS, 3, number of tick_1hz pulses done_beep stays asserted in DONE
QUICK_SEC, 30, seconds loaded by quick start (used only with QUICK_START_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
key_valid  input  1  one-cycle pulse: key_digit is valid
key_digit  input  4  raw keypad code; values 10-15 are clamped to 9
start  input  1  one-cycle start request
stop  input  1  one-cycle stop/clear request
door_open  input  1  level: door is open
tick_1hz  input  1  one-cycle enable pulse, once per second
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
magnetron_on  output  1  high only in COOK
done_beep  output  1  high in DONE while the beep count is running
state_o  output  3  current state encoding, for display/debug

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge.
- Reset values: all four digits 0, state IDLE, magnetron_on 0, done_beep 0, beep counter 0.
- All outputs are registered. Every response occurs on the first rising edge after its input is sampled.
- States: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.
- Digit entry:
  - Applies in IDLE and ENTRY only.
  - On key_valid: {min_tens,min_ones,sec_tens,sec_ones} <= {min_ones,sec_tens,sec_ones,clamp(key_digit)}; the oldest digit is discarded.
  - The first key in IDLE goes to ENTRY.
  - key_valid is ignored in COOK, PAUSE and DONE.
- Entered seconds are not normalised: 0:90 counts 90 s.
- Start rules:
  - From IDLE or ENTRY: start with door closed and time nonzero goes to COOK.
  - Start with time zero is ignored (see the optional feature).
  - Start with door open is ignored.
- COOK: on tick_1hz, decrement BCD as follows.
  - sec_ones > 0: decrement sec_ones.
  - Otherwise sec_ones = 9 and sec_tens is decremented, or set to 5 if it is 0.
  - If sec_tens borrowed, the minutes are decremented the same way, with min_ones wrapping to 9.
  - A tick that reaches 00:00 goes to DONE on the same edge.
- COOK -> PAUSE when door_open=1 or stop=1. The time is held; magnetron_on drops on the same edge.
- PAUSE:
  - start with door closed: go to COOK.
  - stop: clear all digits and go to IDLE.
  - Ticks are ignored.
- DONE:
  - Beep counter loads BCD value BEEP_TICKS on entry; done_beep is high.
  - Each tick decrements the counter. At 0, done_beep clears and the state goes to IDLE.
  - stop, key_valid, start or a door_open rising edge also goes straight to IDLE with done_beep 0. That key is not captured.
- Priority when events coincide in one cycle: stop > door_open > start > tick > key_valid.
  - stop+tick in COOK: no decrement; go to PAUSE.
  - start+key_valid in ENTRY: start is taken; the digit is dropped.
- Reset mid-COOK forces the reset values on that edge; the magnetron is off one cycle later at most.
- Unused state encodings recover to IDLE with the digits cleared.

Optional Feature:
- Macro: COOK_TIMER_QUICK_START_EN.
- Defined:
  - In IDLE/ENTRY, start with time 00:00 and door closed loads QUICK_SEC (default 0:30, split into BCD digits) and goes to COOK.
  - In COOK, start adds 30 s to the remaining time. Seconds-tens saturate at 5 with carry into the minutes; the total saturates at 99:59.
- Not defined:
  - Start with zero time is ignored.
  - Start in COOK is ignored.

Decomposition:
- Package cook_timer_pkg holds:
  - the state enum (IDLE, ENTRY, COOK, PAUSE, DONE) and its 3-bit width;
  - BCD digit width 4;
  - constants BCD_MAX=9 and SEC_TENS_MAX=5.
- Sub-module bcd_digit_clamp (4-bit in, 4-bit out, combinational): saturates codes 10-15 to 9. It is instantiated on key_digit.
- FSM and BCD down-counter stay in the top module.

Test Plan:
- Reset low for 2 cycles -> all digits 0, state_o=0, magnetron_on=0, done_beep=0.
- Keys 1,3,0 -> display 01:30. Start (door closed) -> COOK. 3 ticks -> 01:27. Further ticks: 01:00 -> 00:59.
- Keys 15,7 -> display 00:97 (15 clamped to 9). Five more keys 1,2,3,4,5 -> 23:45.
- COOK at 00:05, door_open=1 -> PAUSE, magnetron_on=0. Tick -> still 00:05. Door closed, start -> COOK. Stop in PAUSE -> 00:00, IDLE.
- COOK at 00:01, tick -> 00:00, DONE, done_beep=1. BEEP_TICKS=3 ticks -> IDLE, done_beep=0. Second run: key press in DONE -> IDLE immediately.
- stop and tick in the same COOK cycle -> PAUSE, no decrement. With COOK_TIMER_QUICK_START_EN, start at 00:00 -> COOK at 00:30; start again -> 01:00.
